// File: rtl/memory_arbiter_if.sv
// Request/ack bundle for the three SRAM requesters plus the SRAM pins.
// The arbiter takes the slave modport; requesters and SRAM sit on the master side.
interface memory_arbiter_if;
    logic        video_stb;
    logic [17:0] video_addr;
    logic        video_ack;
    logic [7:0]  video_rdata;

    logic        cpu_stb;
    logic        cpu_wr;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;

    logic        dma_stb;
    logic        dma_wr;
    logic [17:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;

    logic [17:0] ram_a;
    logic [7:0]  ram_do;
    logic [7:0]  ram_di;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        ram_dq_oe;

    modport slave (
        input  video_stb, video_addr,
        output video_ack, video_rdata,
        input  cpu_stb, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_wait,
        input  dma_stb, dma_wr, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_a, ram_do, ram_oe_n, ram_we_n, ram_dq_oe,
        input  ram_di
    );

    modport master (
        output video_stb, video_addr,
        input  video_ack, video_rdata,
        output cpu_stb, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_wait,
        output dma_stb, dma_wr, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_a, ram_do, ram_oe_n, ram_we_n, ram_dq_oe,
        output ram_di
    );
endinterface

// File: rtl/memory_arbiter.sv
// Three-way SRAM arbiter (video > cpu > dma, anti-starvation for dma); strobe-to-ack 4 cycles,
// one access per 3 cycles; requesters are held off by a pending flag, cpu sees cpu_wait.
module memory_arbiter (
    input  logic              clk28,
    input  logic              rst,
    memory_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2}          state_t;
    typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_DMA} src_t;

    state_t      state_q, state_d;
    logic        vid_pend_q, vid_pend_d, cpu_pend_q, cpu_pend_d, dma_pend_q, dma_pend_d;
    logic [17:0] vid_addr_q, vid_addr_d, cpu_addr_q, cpu_addr_d, dma_addr_q, dma_addr_d;
    logic        cpu_wr_q, cpu_wr_d, dma_wr_q, dma_wr_d;
    logic [7:0]  cpu_wdata_q, cpu_wdata_d, dma_wdata_q, dma_wdata_d;
    logic [2:0]  starve_q, starve_d;
    src_t        gnt_src_q, gnt_src_d;
    logic        gnt_wr_q, gnt_wr_d;
    logic [17:0] gnt_addr_q, gnt_addr_d;
    logic [7:0]  gnt_wdata_q, gnt_wdata_d;
    logic        vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [7:0]  vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

    logic        grant;
    src_t        pick;
    logic        active;
    logic        vid_busy, cpu_busy, dma_busy;

    // A strobe landing in ACC2 is accepted so a requester can queue its next access
    // and stream at the full one-per-3-cycles rate.
    assign active   = (state_q != IDLE);
    assign vid_busy = vid_pend_q || (state_q == ACC1 && gnt_src_q == SRC_VID);
    assign cpu_busy = cpu_pend_q || (state_q == ACC1 && gnt_src_q == SRC_CPU);
    assign dma_busy = dma_pend_q || (state_q == ACC1 && gnt_src_q == SRC_DMA);

    always_comb begin
        state_d     = state_q;
        vid_pend_d  = vid_pend_q;  vid_addr_d  = vid_addr_q;
        cpu_pend_d  = cpu_pend_q;  cpu_addr_d  = cpu_addr_q;
        cpu_wr_d    = cpu_wr_q;    cpu_wdata_d = cpu_wdata_q;
        dma_pend_d  = dma_pend_q;  dma_addr_d  = dma_addr_q;
        dma_wr_d    = dma_wr_q;    dma_wdata_d = dma_wdata_q;
        starve_d    = starve_q;
        gnt_src_d   = gnt_src_q;   gnt_wr_d    = gnt_wr_q;
        gnt_addr_d  = gnt_addr_q;  gnt_wdata_d = gnt_wdata_q;
        vid_ack_d   = 1'b0;        cpu_ack_d   = 1'b0;        dma_ack_d = 1'b0;
        vid_rdata_d = vid_rdata_q; cpu_rdata_d = cpu_rdata_q; dma_rdata_d = dma_rdata_q;
        grant       = 1'b0;
        pick        = SRC_VID;

        if (bus.video_stb && !vid_busy) begin
            vid_pend_d = 1'b1;
            vid_addr_d = bus.video_addr;
        end
        if (bus.cpu_stb && !cpu_busy) begin
            cpu_pend_d  = 1'b1;
            cpu_addr_d  = bus.cpu_addr;
            cpu_wr_d    = bus.cpu_wr;
            cpu_wdata_d = bus.cpu_wdata;
        end
        if (bus.dma_stb && !dma_busy) begin
            dma_pend_d  = 1'b1;
            dma_addr_d  = bus.dma_addr;
            dma_wr_d    = bus.dma_wr;
            dma_wdata_d = bus.dma_wdata;
        end

        case (state_q)
            IDLE: begin
                if (vid_pend_q)                             begin grant = 1'b1; pick = SRC_VID; end
                else if (dma_pend_q && starve_q == 3'd7)    begin grant = 1'b1; pick = SRC_DMA; end
                else if (cpu_pend_q)                        begin grant = 1'b1; pick = SRC_CPU; end
                else if (dma_pend_q)                        begin grant = 1'b1; pick = SRC_DMA; end

                if (grant) begin
                    state_d   = ACC1;
                    gnt_src_d = pick;
                    case (pick)
                        SRC_VID: begin
                            vid_pend_d  = 1'b0;
                            gnt_wr_d    = 1'b0;
                            gnt_addr_d  = vid_addr_q;
                            gnt_wdata_d = 8'h00;
                        end
                        SRC_CPU: begin
                            cpu_pend_d  = 1'b0;
                            gnt_wr_d    = cpu_wr_q;
                            gnt_addr_d  = cpu_addr_q;
                            gnt_wdata_d = cpu_wdata_q;
                            if (dma_pend_q && starve_q != 3'd7)
                                starve_d = starve_q + 3'd1;
                        end
                        default: begin
                            dma_pend_d  = 1'b0;
                            gnt_wr_d    = dma_wr_q;
                            gnt_addr_d  = dma_addr_q;
                            gnt_wdata_d = dma_wdata_q;
                            starve_d    = 3'd0;
                        end
                    endcase
                end
            end
            ACC1: state_d = ACC2;
            ACC2: begin
                state_d = IDLE;
                case (gnt_src_q)
                    SRC_VID: begin
                        vid_ack_d = 1'b1;
                        if (!gnt_wr_q) vid_rdata_d = bus.ram_di;
                    end
                    SRC_CPU: begin
                        cpu_ack_d = 1'b1;
                        if (!gnt_wr_q) cpu_rdata_d = bus.ram_di;
                    end
                    default: begin
                        dma_ack_d = 1'b1;
                        if (!gnt_wr_q) dma_rdata_d = bus.ram_di;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q     <= IDLE;
            vid_pend_q  <= 1'b0;  cpu_pend_q  <= 1'b0;  dma_pend_q <= 1'b0;
            vid_addr_q  <= '0;    cpu_addr_q  <= '0;    dma_addr_q <= '0;
            cpu_wr_q    <= 1'b0;  dma_wr_q    <= 1'b0;
            cpu_wdata_q <= '0;    dma_wdata_q <= '0;
            starve_q    <= 3'd0;
            gnt_src_q   <= SRC_VID;
            gnt_wr_q    <= 1'b0;
            gnt_addr_q  <= '0;
            gnt_wdata_q <= '0;
            vid_ack_q   <= 1'b0;  cpu_ack_q   <= 1'b0;  dma_ack_q  <= 1'b0;
            vid_rdata_q <= 8'hFF; cpu_rdata_q <= 8'hFF; dma_rdata_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            vid_pend_q  <= vid_pend_d;  cpu_pend_q  <= cpu_pend_d;  dma_pend_q <= dma_pend_d;
            vid_addr_q  <= vid_addr_d;  cpu_addr_q  <= cpu_addr_d;  dma_addr_q <= dma_addr_d;
            cpu_wr_q    <= cpu_wr_d;    dma_wr_q    <= dma_wr_d;
            cpu_wdata_q <= cpu_wdata_d; dma_wdata_q <= dma_wdata_d;
            starve_q    <= starve_d;
            gnt_src_q   <= gnt_src_d;
            gnt_wr_q    <= gnt_wr_d;
            gnt_addr_q  <= gnt_addr_d;
            gnt_wdata_q <= gnt_wdata_d;
            vid_ack_q   <= vid_ack_d;   cpu_ack_q   <= cpu_ack_d;   dma_ack_q  <= dma_ack_d;
            vid_rdata_q <= vid_rdata_d; cpu_rdata_q <= cpu_rdata_d; dma_rdata_q <= dma_rdata_d;
        end
    end

    // SRAM strobes decode straight from state so they can never overlap.
    assign bus.ram_a       = gnt_addr_q;
    assign bus.ram_do      = gnt_wdata_q;
    assign bus.ram_oe_n    = !(active && !gnt_wr_q);
    assign bus.ram_we_n    = !(state_q == ACC2 && gnt_wr_q);
    assign bus.ram_dq_oe   = active && gnt_wr_q;

    assign bus.video_ack   = vid_ack_q;
    assign bus.video_rdata = vid_rdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_wait    = cpu_pend_q || (active && gnt_src_q == SRC_CPU);
    assign bus.dma_ack     = dma_ack_q;
    assign bus.dma_rdata   = dma_rdata_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural asynchronous SRAM.
module tb_memory_arbiter;
    logic clk28;
    logic rst;
    memory_arbiter_if bus();

    memory_arbiter dut (.clk28(clk28), .rst(rst), .bus(bus));

    bit [7:0] mem [0:262143];
    assign bus.ram_di = mem[bus.ram_a];
    always @(posedge clk28) if (!bus.ram_we_n) mem[bus.ram_a] = bus.ram_do;

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    int total = 0;
    int bad   = 0;

    int vid_acks, cpu_acks, dma_acks, cpu_pre;
    int vid_ack_at, cpu_ack_at, dma_ack_at;
    int oe_cnt;
    logic [31:0] we_mask, dq_mask, wait_mask;
    logic [17:0] a_at2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic clr_stats();
        vid_acks = 0; cpu_acks = 0; dma_acks = 0; cpu_pre = 0;
        vid_ack_at = -1; cpu_ack_at = -1; dma_ack_at = -1;
        oe_cnt = 0; we_mask = '0; dq_mask = '0; wait_mask = '0; a_at2 = '0;
    endtask

    task automatic clr_stb();
        bus.video_stb = 1'b0; bus.cpu_stb = 1'b0; bus.dma_stb = 1'b0;
    endtask

    // k = cycles since the strobe cycle
    task automatic sample(input int k);
        if (bus.video_ack) begin vid_acks++; if (vid_ack_at < 0) vid_ack_at = k; end
        if (bus.cpu_ack) begin
            cpu_acks++;
            if (cpu_ack_at < 0) cpu_ack_at = k;
            if (dma_ack_at < 0) cpu_pre++;
        end
        if (bus.dma_ack) begin dma_acks++; if (dma_ack_at < 0) dma_ack_at = k; end
        if (!bus.ram_oe_n) oe_cnt++;
        if (!bus.ram_we_n)  we_mask   |= 32'd1 << k;
        if (bus.ram_dq_oe)  dq_mask   |= 32'd1 << k;
        if (bus.cpu_wait)   wait_mask |= 32'd1 << k;
        if (k == 2) a_at2 = bus.ram_a;
        chk("oe_we_excl", {31'b0, (!bus.ram_oe_n && !bus.ram_we_n)}, 32'd0);
        chk("dq_on_read", {31'b0, (bus.ram_dq_oe && !bus.ram_oe_n)}, 32'd0);
    endtask

    task automatic watch(input int n);
        clr_stats();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 1) clr_stb();
            sample(k);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acks"}, {29'b0, bus.video_ack, bus.cpu_ack, bus.dma_ack}, 32'd0);
        chk({tag, "_wait"}, {31'b0, bus.cpu_wait}, 32'd0);
        chk({tag, "_ramctl"}, {29'b0, bus.ram_oe_n, bus.ram_we_n, bus.ram_dq_oe}, 32'b110);
        chk({tag, "_ram_a"}, {14'b0, bus.ram_a}, 32'd0);
        chk({tag, "_ram_do"}, {24'b0, bus.ram_do}, 32'd0);
        chk({tag, "_rdata"}, {8'b0, bus.video_rdata, bus.cpu_rdata, bus.dma_rdata}, 32'hFFFFFF);
    endtask

    initial begin
        rst = 1'b1;
        clr_stb();
        bus.video_addr = '0;
        bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        mem[18'h04000] = 8'h5A;
        mem[18'h00100] = 8'h11;
        mem[18'h00200] = 8'h22;
        mem[18'h00300] = 8'h33;
        mem[18'h00500] = 8'h77;
        mem[18'h00600] = 8'h66;
        mem[18'h00700] = 8'h71;
        mem[18'h00800] = 8'h81;

        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // CPU read, uncontended
        bus.cpu_stb = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 18'h04000;
        watch(6);
        chk("rd_ack_cycle", cpu_ack_at, 4);
        chk("rd_ack_count", cpu_acks, 1);
        chk("rd_rdata", bus.cpu_rdata, 8'h5A);
        chk("rd_oe_cycles", oe_cnt, 2);
        chk("rd_ram_a", a_at2, 18'h04000);
        chk("rd_wait_mask", wait_mask, 32'hE);
        chk("rd_dq_mask", dq_mask, 0);

        // DMA write
        bus.dma_stb = 1'b1; bus.dma_wr = 1'b1; bus.dma_addr = 18'h1FFFF; bus.dma_wdata = 8'h3C;
        watch(6);
        chk("wr_ack_cycle", dma_ack_at, 4);
        chk("wr_we_mask", we_mask, 32'h8);
        chk("wr_dq_mask", dq_mask, 32'hC);
        chk("wr_oe_cycles", oe_cnt, 0);
        chk("wr_ram_a", a_at2, 18'h1FFFF);
        chk("wr_mem", mem[18'h1FFFF], 8'h3C);
        chk("wr_rdata_kept", bus.dma_rdata, 8'hFF);

        // all three strobe together
        bus.video_stb = 1'b1; bus.video_addr = 18'h00100;
        bus.cpu_stb = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 18'h00200;
        bus.dma_stb = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = 18'h00300;
        watch(12);
        chk("all_vid_ack", vid_ack_at, 4);
        chk("all_cpu_ack", cpu_ack_at, 7);
        chk("all_dma_ack", dma_ack_at, 10);
        chk("all_rdata", {8'b0, bus.video_rdata, bus.cpu_rdata, bus.dma_rdata}, 32'h112233);
        chk("all_oe_cycles", oe_cnt, 6);

        // dma starvation relief under a cpu stream
        clr_stats();
        bus.cpu_stb = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 18'h04000;
        bus.dma_stb = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = 18'h00500;
        for (int k = 1; k <= 30; k++) begin
            tick();
            bus.cpu_stb = (k % 3 == 0) && (k <= 21);
            bus.dma_stb = 1'b0;
            sample(k);
        end
        chk("starve_dma_ack", dma_ack_at, 25);
        chk("starve_cpu_before", cpu_pre, 7);
        chk("starve_cpu_total", cpu_acks, 8);
        chk("starve_dma_rdata", bus.dma_rdata, 8'h77);
        chk("starve_cnt_clear", {29'b0, dut.starve_q}, 0);

        // reset during ACC2 of a cpu read
        bus.cpu_stb = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 18'h00600;
        tick(); clr_stb();
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        watch(3);
        chk("midrst_no_ack", cpu_acks, 0);
        bus.cpu_stb = 1'b1; bus.cpu_addr = 18'h00600;
        watch(6);
        chk("midrst_next_ack", cpu_ack_at, 4);
        chk("midrst_next_rdata", bus.cpu_rdata, 8'h66);

        // duplicate strobe while pending
        clr_stats();
        bus.cpu_stb = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 18'h00700;
        tick();
        sample(1);
        bus.cpu_addr = 18'h00800;
        tick();
        clr_stb();
        sample(2);
        for (int k = 3; k <= 8; k++) begin
            tick();
            sample(k);
        end
        chk("dup_ack_count", cpu_acks, 1);
        chk("dup_ack_cycle", cpu_ack_at, 4);
        chk("dup_ram_a", a_at2, 18'h00700);
        chk("dup_rdata", bus.cpu_rdata, 8'h71);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
